// File: rtl/fpaddsub_normalize_lzc_stage.sv
// Normalize front stage of the FP add/sub pipeline: leading-zero count of the
// raw sum mantissa, exponent-aware shift clamp, the coarse 16-bit pre-shift, and
// one registered output slot with valid/ready handshaking.
module fpaddsub_normalize_lzc_stage #(
  parameter int MW = 26,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] SumM,
  input  logic [EW-1:0] ExpIn,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] MminP,
  output logic [4:0]    Shift,
  output logic [EW-1:0] ExpOut,
  output logic          Zero
);

  // Shift amounts are carried as 5 bits; bit 4 is the 16-position pre-shift
  // applied here, the lower bits are consumed by the downstream shifters.
  localparam int SW = 5;

  logic [SW-1:0] lzcCount;
  logic          leadFound;
  logic          sumIsZero;

  logic [SW-1:0] shift_d;
  logic [EW-1:0] expOut_d;
  logic          zero_d;
  logic [MW-1:0] mminP_d;

  logic          load;
  logic          outValid_d;

  logic          outValid_q;
  logic [SW-1:0] shift_q;
  logic [EW-1:0] expOut_q;
  logic          zero_q;
  logic [MW-1:0] mminP_q;

  assign sumIsZero = (SumM == '0);

  // Leading-zero count: scan from the MSB and stop counting at the first one.
  always_comb begin
    lzcCount  = '0;
    leadFound = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!leadFound) begin
        if (SumM[i]) begin
          leadFound = 1'b1;
        end else begin
          lzcCount = lzcCount + SW'(1);
        end
      end
    end
  end

  // Shift clamp: a full normalize shift is only allowed while the exponent can
  // absorb it; otherwise shift just far enough to land on a denormal (exp 0).
  // In the clamped branch ExpIn <= lzcCount <= MW-1, so its low bits suffice.
  always_comb begin
    shift_d  = '0;
    expOut_d = '0;
    zero_d   = 1'b0;
    if (sumIsZero) begin
      zero_d = 1'b1;
    end else if (EW'(lzcCount) < ExpIn) begin
      shift_d  = lzcCount;
      expOut_d = ExpIn - EW'(lzcCount);
    end else begin
      shift_d  = (ExpIn == '0) ? '0 : (ExpIn[SW-1:0] - SW'(1));
      expOut_d = '0;
    end
  end

  // Coarse pre-shift by 16 with zero fill when bit 4 of the shift is set.
  always_comb begin
    mminP_d = SumM;
    if (shift_d[SW-1]) begin
      mminP_d = {SumM[MW-17:0], 16'b0};
    end
  end

  // The slot can accept when it is empty or is being emptied this cycle;
  // in_ready never depends on in_valid.
  assign in_ready   = ~outValid_q | out_ready;
  assign load       = in_valid & in_ready;
  assign outValid_d = load | (outValid_q & ~out_ready);

  // Valid flag: set on load, cleared on a drain with nothing new arriving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
    end
  end

  // Data registers update only on load and otherwise hold (stall or drain).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mminP_q  <= '0;
      shift_q  <= '0;
      expOut_q <= '0;
      zero_q   <= 1'b0;
    end else if (load) begin
      mminP_q  <= mminP_d;
      shift_q  <= shift_d;
      expOut_q <= expOut_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid = outValid_q;
  assign MminP     = mminP_q;
  assign Shift     = shift_q;
  assign ExpOut    = expOut_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_fpaddsub_normalize_lzc_stage.sv
// Scoreboard bench for the normalize LZC stage: a driver pushes the expected
// result of every accepted item, a negedge monitor compares the held output
// against the queue head each cycle and pops it when it is consumed.
module tb_fpaddsub_normalize_lzc_stage;

  localparam int MW = 26;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] SumM;
  logic [EW-1:0] ExpIn;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] MminP;
  logic [4:0]    Shift;
  logic [EW-1:0] ExpOut;
  logic          Zero;

  typedef struct {
    logic [MW-1:0] m;
    logic [4:0]    s;
    logic [EW-1:0] e;
    logic          z;
  } expT;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;
  bit  monEn = 1'b0;
  bit  randDone = 1'b0;

  fpaddsub_normalize_lzc_stage #(.MW(MW), .EW(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .SumM     (SumM),
    .ExpIn    (ExpIn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .MminP    (MminP),
    .Shift    (Shift),
    .ExpOut   (ExpOut),
    .Zero     (Zero)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference: normalize arithmetically by doubling the value until the top
  // bit is reached, then apply the exponent clamp and the 16-step pre-shift.
  function automatic expT refModel(input logic [MW-1:0] sum, input logic [EW-1:0] ex);
    expT    r;
    longint v;
    longint top;
    int     lz;
    int     e;
    int     sh;
    r.m = '0;
    r.s = '0;
    r.e = '0;
    r.z = 1'b0;
    e   = int'(ex);
    if (sum == '0) begin
      r.z = 1'b1;
    end else begin
      v   = longint'(sum);
      top = longint'(1) << (MW - 1);
      lz  = 0;
      while (v < top) begin
        v  = v * 2;
        lz = lz + 1;
      end
      if (lz < e) begin
        sh  = lz;
        r.e = EW'(e - lz);
      end else begin
        sh  = (e == 0) ? 0 : e - 1;
        r.e = '0;
      end
      r.s = 5'(sh);
      if (sh >= 16) r.m = MW'((longint'(sum) * 65536) % (longint'(1) << MW));
      else          r.m = sum;
    end
    return r;
  endfunction

  // Single scalar comparison with a FAIL line on mismatch.
  task automatic checkVal(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, req);
    end
  endtask

  // Compare the registered outputs against one scoreboard entry.
  task automatic checkOutput(input expT ex);
    checkVal("MminP", longint'(MminP), longint'(ex.m));
    checkVal("Shift", longint'(Shift), longint'(ex.s));
    checkVal("ExpOut", longint'(ExpOut), longint'(ex.e));
    checkVal("Zero", longint'(Zero), longint'(ex.z));
  endtask

  // Present one item and hold it until accepted; push its expected result.
  // Entered and left at posedge+1 so inputs never move near the active edge.
  task automatic applyStimulus(input logic [MW-1:0] sum, input logic [EW-1:0] ex);
    SumM     = sum;
    ExpIn    = ex;
    in_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(refModel(sum, ex));
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("[TB] FAIL accept_timeout: item sum=0x%0h not accepted within 200 cycles", sum);
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle out of reset, check the ready rule and compare the
  // held item to the queue head; pop when the downstream takes it.
  always @(negedge clk) begin
    if (monEn && rst) begin
      checkVal("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
      if (out_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got MminP=0x%0h with empty scoreboard", MminP);
        end else begin
          checkOutput(expQ[0]);
          if (out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  // Main sequence: reset, directed cases, backpressure, reset mid-stall, random.
  initial begin
    logic [MW-1:0] rs;
    rst       = 1'b0;
    in_valid  = 1'b1;
    SumM      = 26'h2000000;
    ExpIn     = 8'd100;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", longint'(out_valid), 0);
    checkVal("rst_MminP", longint'(MminP), 0);
    checkVal("rst_Shift", longint'(Shift), 0);
    checkVal("rst_ExpOut", longint'(ExpOut), 0);
    checkVal("rst_Zero", longint'(Zero), 0);
    checkVal("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    monEn = 1'b1;

    applyStimulus(26'h2000000, 8'd100);
    checkVal("first_load_valid", longint'(out_valid), 1);
    applyStimulus(26'h0000100, 8'd120);
    applyStimulus(26'h0000100, 8'd5);
    applyStimulus(26'h0000100, 8'd0);
    applyStimulus(26'h0000000, 8'd77);
    applyStimulus(26'h0000001, 8'd255);
    applyStimulus(26'h0000001, 8'd25);
    applyStimulus(26'h0000001, 8'd26);
    applyStimulus(26'h0008000, 8'd11);
    applyStimulus(26'h0008000, 8'd10);
    repeat (3) idleCycle();

    out_ready = 1'b0;
    applyStimulus(26'h0000100, 8'd120);
    fork
      begin
        applyStimulus(26'h1234567, 8'd40);
        applyStimulus(26'h0000ABC, 8'd200);
        applyStimulus(26'h0000003, 8'd3);
        in_valid = 1'b0;
      end
      begin
        repeat (4) begin
          @(negedge clk);
          checkVal("stall_in_ready", longint'(in_ready), 0);
          checkVal("stall_out_valid", longint'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) idleCycle();
    checkVal("bp_drained", longint'(expQ.size()), 0);

    out_ready = 1'b0;
    applyStimulus(26'h0F0F0F0, 8'd60);
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checkVal("async_rst_valid", longint'(out_valid), 0);
    checkVal("async_rst_in_ready", longint'(in_ready), 1);
    checkVal("async_rst_MminP", longint'(MminP), 0);
    checkVal("async_rst_Shift", longint'(Shift), 0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    idleCycle();

    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 3) == 0) idleCycle();
          rs = MW'($urandom) >> $urandom_range(0, MW);
          if ($urandom_range(0, 1) == 0) applyStimulus(rs, EW'($urandom_range(0, 30)));
          else                           applyStimulus(rs, EW'($urandom));
        end
        in_valid = 1'b0;
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 50 && expQ.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    checkVal("final_drain_empty", longint'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpaddsub_normalize_lzc_stage.md
Name: fpaddsub_normalize_lzc_stage

Overview:
- Pipeline stage directly upstream of the coarse normalize shifter (the 0/4/8/12 rotate stage).
- Counts leading zeros of the 26-bit post-add mantissa and clamps the shift amount against the exponent so denormals stay denormal.
- Applies the 16-bit pre-shift and registers the pre-shifted mantissa (MminP), the 5-bit Shift, the adjusted exponent and a zero flag.
- One registered slot with valid/ready flow control.

Parameters:
- MW, 26, mantissa width; bit MW-1 is the normalized leading-one position.
- EW, 8, exponent width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept data this cycle.
- SumM  input  MW  unnormalized mantissa from the adder (carry already handled upstream).
- ExpIn  input  EW  exponent associated with SumM.
- out_valid  output  1  registered outputs hold a valid item.
- out_ready  input  1  downstream accepts the item.
- MminP  output  MW  mantissa after the 0/16 pre-shift; feeds the coarse shifter.
- Shift  output  5  total left-shift amount; bit 4 already applied here, bits [3:2] used by the next stage, bits [1:0] by the fine stage.
- ExpOut  output  EW  exponent after normalization adjustment.
- Zero  output  1  SumM was all zero.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, MminP=0, Shift=0, ExpOut=0, Zero=0. Reset asserted mid-transfer drops the held item; no partial update survives.
- in_ready = ~out_valid | out_ready (combinational). No combinational path from in_valid to in_ready.
- Load: on a clock edge with in_valid & in_ready, all output registers load from the combinational datapath and out_valid becomes 1.
- Drain: on an edge with out_valid & out_ready & ~in_valid, out_valid becomes 0 and the data registers hold their value.
- Simultaneous load and drain in the same cycle: the new item replaces the old one; out_valid stays 1. Throughput is 1 item/cycle; latency is 1 cycle.
- Stall: while out_valid & ~out_ready, all outputs are held stable, in_ready=0, and SumM/ExpIn are ignored.
- LZC: number of leading zeros of SumM counted from bit MW-1, range 0..MW-1 for non-zero inputs.
- Shift clamp:
  - SumM==0: Zero=1, Shift=0, ExpOut=0, MminP=0.
  - Else if LZC < ExpIn: Shift=LZC, ExpOut=ExpIn-LZC.
  - Else (denormal result): Shift = (ExpIn==0) ? 0 : ExpIn-1, and ExpOut=0.
  - Comparison is done at EW bits with Shift zero-extended; Shift never exceeds MW-1.
- Pre-shift: MminP = Shift[4] ? (SumM << 16) with zero fill : SumM. The shift is logical, never a rotate.
- Zero=0 for every non-zero input.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1; release rst -> the first valid input loads on the next edge.
- Normalized input: SumM=26'h2000000, ExpIn=100 -> after 1 cycle Shift=0, MminP=26'h2000000, ExpOut=100, Zero=0.
- Deep shift: SumM=26'h0000100, ExpIn=120 -> LZC=17, Shift=17 (5'b10001), MminP=26'h1000000, ExpOut=103.
- Denormal clamp: SumM=26'h0000100, ExpIn=5 -> Shift=4, MminP=26'h0000100, ExpOut=0. With ExpIn=0 -> Shift=0, ExpOut=0.
- Zero: SumM=0, ExpIn=77 -> Zero=1, Shift=0, ExpOut=0, MminP=0.
- Backpressure: stream 4 items with out_ready held low after the first load -> out_valid=1, outputs frozen on item 1, in_ready=0.
  - Raise out_ready -> items leave in order at 1 per cycle.
  - Assert rst mid-stall -> out_valid=0 immediately (asynchronous).
